// File: rtl/encoder_speed_match.sv
// ---------------------------------------------------------------------------
// encoder_speed_match
//
// Closed-loop wheel speed matcher for NUM_CH encoder channels.
//
// Each channel's encoder edges are counted over a fixed window of WINDOW
// clocks. Channel 0 is the master. At the end of each window the slave
// duties are nudged by a shifted copy of (master count - slave count), so
// the slave wheels track the master wheel. The block sits between the
// encoder pins and the PWM generators.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high
//   brake        motors braking; counting and correction suspended
//   coast        motors coasting; same effect as brake
//   enc          encoder phase per channel (asynchronous)
//   duty_base    commanded duty for the master channel
//   gain_shift   right shift applied to the count error (P gain = 2^-gain_shift)
//   duty         duty per channel, channel i at [i*DUTY_W +: DUTY_W]
//   sat          per-channel clamp flag from the last update (bit 0 always 0)
//   sample_valid one-cycle pulse once every duty has been updated
// ---------------------------------------------------------------------------
module encoder_speed_match #(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 8,
    parameter int DUTY_W    = 6,
    parameter int WINDOW    = 100000,
    parameter int EDGE_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       brake,
    input  logic                       coast,
    input  logic [NUM_CH-1:0]          enc,
    input  logic [DUTY_W-1:0]          duty_base,
    input  logic [2:0]                 gain_shift,
    output logic [NUM_CH*DUTY_W-1:0]   duty,
    output logic [NUM_CH-1:0]          sat,
    output logic                       sample_valid
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int K_W   = $clog2(NUM_CH + 1);
    localparam int SUM_W = DUTY_W + CNT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Registered state
    logic [NUM_CH-1:0] enc_s1_q, enc_s1_d;
    logic [NUM_CH-1:0] enc_s2_q, enc_s2_d;
    logic [NUM_CH-1:0] enc_prev_q, enc_prev_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  snap_q [NUM_CH];
    logic [CNT_W-1:0]  snap_d [NUM_CH];
    logic [DUTY_W-1:0] duty_q [NUM_CH];
    logic [DUTY_W-1:0] duty_d [NUM_CH];
    logic [WIN_W-1:0]  win_q, win_d;
    state_t            state_q, state_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [2:0]        gain_hold_q, gain_hold_d;
    logic [DUTY_W-1:0] base_hold_q, base_hold_d;
    logic [NUM_CH-1:0] sat_q, sat_d;
    logic              sample_valid_q, sample_valid_d;
    logic              primed_q, primed_d;

    // Combinational helpers
    logic                    run;
    logic                    win_term;
    logic [NUM_CH-1:0]       enc_edge;
    logic [CNT_W-1:0]        snap_k;
    logic [DUTY_W-1:0]       duty_k;
    logic signed [CNT_W:0]   err;
    logic signed [CNT_W:0]   corr;
    logic signed [SUM_W-1:0] sum;
    logic [DUTY_W-1:0]       duty_new;
    logic                    sat_new;

    // Next-state logic. Braking/coasting overrides everything except reset:
    // the whole loop is parked with zero duty and must re-prime on release,
    // because the wheels are no longer in a known relationship to each other.
    // The correction datapath picks the snapshot and duty of slave k_q and
    // clamps the signed sum into the duty range.
    always_comb begin
        run        = ~brake & ~coast;
        win_term   = (win_q == WIN_W'(WINDOW - 1));
        enc_edge   = (EDGE_MODE != 0) ? (enc_s2_q ^ enc_prev_q)
                                      : (enc_s2_q & ~enc_prev_q);

        enc_s1_d       = enc;
        enc_s2_d       = enc_s1_q;
        enc_prev_d     = enc_s2_q;
        cnt_d          = cnt_q;
        snap_d         = snap_q;
        duty_d         = duty_q;
        win_d          = win_q;
        state_d        = state_q;
        k_d            = k_q;
        gain_hold_d    = gain_hold_q;
        base_hold_d    = base_hold_q;
        sat_d          = sat_q;
        sample_valid_d = 1'b0;
        primed_d       = primed_q;

        // Slave k_q operands; the loop avoids indexing arrays with k_q,
        // whose width is not the array index width.
        snap_k = '0;
        duty_k = '0;
        for (int i = 1; i < NUM_CH; i++) begin
            if (k_q == K_W'(i)) begin
                snap_k = snap_q[i];
                duty_k = duty_q[i];
            end
        end

        // err > 0 means the slave is slower, which raises its duty.
        err  = $signed({1'b0, snap_q[0]}) - $signed({1'b0, snap_k});
        corr = err >>> gain_hold_q;
        sum  = $signed({{(SUM_W - DUTY_W){1'b0}}, duty_k})
             + $signed({{(SUM_W - CNT_W - 1){corr[CNT_W]}}, corr});

        if (sum[SUM_W-1]) begin
            duty_new = '0;
            sat_new  = 1'b1;
        end else if (|sum[SUM_W-2:DUTY_W]) begin
            duty_new = '1;
            sat_new  = 1'b1;
        end else begin
            duty_new = sum[DUTY_W-1:0];
            sat_new  = 1'b0;
        end

        if (!run) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i]  = '0;
                duty_d[i] = '0;
            end
            win_d    = '0;
            sat_d    = '0;
            state_d  = IDLE;
            k_d      = '0;
            primed_d = 1'b0;
        end else begin
            case (state_q)
                CALC: begin
                    for (int i = 1; i < NUM_CH; i++) begin
                        if (k_q == K_W'(i)) begin
                            if (primed_q) begin
                                duty_d[i] = duty_new;
                                sat_d[i]  = sat_new;
                            end else begin
                                duty_d[i] = base_hold_q;
                                sat_d[i]  = 1'b0;
                            end
                        end
                    end
                    if (k_q == K_W'(NUM_CH - 1)) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
                DONE: begin
                    sample_valid_d = 1'b1;
                    primed_d       = 1'b1;
                    state_d        = IDLE;
                end
                default: begin
                end
            endcase

            // An edge seen in the terminal cycle is dropped on purpose so it
            // is never counted in two windows.
            if (win_term) begin
                win_d       = '0;
                gain_hold_d = gain_shift;
                base_hold_d = duty_base;
                duty_d[0]   = duty_base;
                state_d     = (NUM_CH > 1) ? CALC : DONE;
                k_d         = K_W'(1);
                for (int i = 0; i < NUM_CH; i++) begin
                    snap_d[i] = cnt_q[i];
                    cnt_d[i]  = '0;
                end
            end else begin
                win_d = win_q + WIN_W'(1);
                for (int i = 0; i < NUM_CH; i++) begin
                    if (enc_edge[i] && (cnt_q[i] != '1)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_s1_q       <= '0;
            enc_s2_q       <= '0;
            enc_prev_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
                duty_q[i] <= '0;
            end
            win_q          <= '0;
            state_q        <= IDLE;
            k_q            <= '0;
            gain_hold_q    <= '0;
            base_hold_q    <= '0;
            sat_q          <= '0;
            sample_valid_q <= 1'b0;
            primed_q       <= 1'b0;
        end else begin
            enc_s1_q       <= enc_s1_d;
            enc_s2_q       <= enc_s2_d;
            enc_prev_q     <= enc_prev_d;
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            duty_q         <= duty_d;
            win_q          <= win_d;
            state_q        <= state_d;
            k_q            <= k_d;
            gain_hold_q    <= gain_hold_d;
            base_hold_q    <= base_hold_d;
            sat_q          <= sat_d;
            sample_valid_q <= sample_valid_d;
            primed_q       <= primed_d;
        end
    end

    // Flatten the per-channel duty registers onto the output bus.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_duty_out
        assign duty[g*DUTY_W +: DUTY_W] = duty_q[g];
    end

    assign sat          = sat_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_encoder_speed_match.sv
// ---------------------------------------------------------------------------
// tb_encoder_speed_match
//
// Drives whole sample windows of encoder pulses into encoder_speed_match and
// compares duty, sat and sample_valid against a window-level model: each
// window the bench decides how many pulses every channel gets, turns that
// into an edge count, and computes the expected duties with plain integer
// arithmetic (floor division for the gain, clamping to the duty range).
// ---------------------------------------------------------------------------
module tb_encoder_speed_match;

    localparam int NUM_CH    = 3;
    localparam int CNT_W     = 4;
    localparam int DUTY_W    = 6;
    localparam int WINDOW    = 40;
    localparam int EDGE_MODE = 1;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int DMAX      = (1 << DUTY_W) - 1;
    localparam int NDIR      = 12;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     brake;
    logic                     coast;
    logic [NUM_CH-1:0]        enc;
    logic [DUTY_W-1:0]        duty_base;
    logic [2:0]               gain_shift;
    logic [NUM_CH*DUTY_W-1:0] duty;
    logic [NUM_CH-1:0]        sat;
    logic                     sample_valid;

    int compared   = 0;
    int mismatched = 0;

    // Window-level model state
    int pulses  [NUM_CH];
    int expDuty [NUM_CH];
    int expSat  [NUM_CH];
    bit primed;
    bit havePrev;
    int baseNow;
    int gainNow;

    // Directed windows: pulses per channel, duty_base, gain_shift
    int dirP0   [NDIR] = '{2, 5, 5, 15, 15, 15,  0,  0, 0,  0,  0,  0};
    int dirP1   [NDIR] = '{2, 3, 7,  0,  0,  0, 15, 15, 2, 15, 15, 15};
    int dirP2   [NDIR] = '{2, 7, 3, 15, 15, 15,  0,  1, 3,  0,  0,  0};
    int dirBase [NDIR] = '{32, 32, 32, 60, 60, 60, 5, 5, 5, 5, 5, 5};
    int dirGain [NDIR] = '{0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0};

    encoder_speed_match #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .DUTY_W    (DUTY_W),
        .WINDOW    (WINDOW),
        .EDGE_MODE (EDGE_MODE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .brake        (brake),
        .coast        (coast),
        .enc          (enc),
        .duty_base    (duty_base),
        .gain_shift   (gain_shift),
        .duty         (duty),
        .sat          (sat),
        .sample_valid (sample_valid)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] dutyOf(input int ch);
        return 32'(duty[ch*DUTY_W +: DUTY_W]);
    endfunction

    function automatic int floorShift(input int v, input int s);
        int d;
        d = 1 << s;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // Expected results of a completed window, applied to the model duties.
    task automatic modelWindow();
        int cnt [NUM_CH];
        int err;
        int sum;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt[ch] = pulses[ch] * ((EDGE_MODE != 0) ? 2 : 1);
            if (cnt[ch] > CMAX) cnt[ch] = CMAX;
        end
        expDuty[0] = baseNow;
        expSat[0]  = 0;
        for (int k = 1; k < NUM_CH; k++) begin
            if (!primed) begin
                expDuty[k] = baseNow;
                expSat[k]  = 0;
            end else begin
                err = cnt[0] - cnt[k];
                sum = expDuty[k] + floorShift(err, gainNow);
                if (sum < 0) begin
                    expDuty[k] = 0;
                    expSat[k]  = 1;
                end else if (sum > DMAX) begin
                    expDuty[k] = DMAX;
                    expSat[k]  = 1;
                end else begin
                    expDuty[k] = sum;
                    expSat[k]  = 0;
                end
            end
        end
        primed   = 1'b1;
        havePrev = 1'b1;
    endtask

    // Park the loop with brake and/or coast; enc wiggles first, then rests
    // low so the released window starts from a quiet synchroniser.
    task automatic brakeSequence(input int mode);
        int h;
        h = 4 + int'($urandom % 5);
        brake = (mode != 1);
        coast = (mode != 0);
        for (int i = 0; i < h; i++) begin
            enc = (i < h - 3) ? NUM_CH'($urandom) : '0;
            @(negedge clk);
            checkOutput("brake_duty", 32'(duty), 32'd0);
            checkOutput("brake_sat", 32'(sat), 32'd0);
            checkOutput("brake_sv", 32'(sample_valid), 32'd0);
        end
        brake = 1'b0;
        coast = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            expDuty[ch] = 0;
            expSat[ch]  = 0;
        end
        primed   = 1'b0;
        havePrev = 1'b0;
    endtask

    // One sample window of stimulus. The previous window's update is checked
    // in the first cycles: slave 1 one cycle after the terminal cycle, and
    // the complete result together with the sample_valid pulse.
    task automatic applyStimulus(input bit doBrake, input int brakeMode);
        logic [NUM_CH-1:0] satExp;
        duty_base  = DUTY_W'(baseNow);
        gain_shift = 3'(gainNow);
        for (int c = 0; c < WINDOW; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                enc[ch] = (c >= 4) && (c < 4 + 2 * pulses[ch]) && (((c - 4) % 2) == 0);
            end
            @(negedge clk);
            if (havePrev) begin
                if (c == 0) checkOutput("duty1_latency", dutyOf(1), 32'(expDuty[1]));
                if (c == 1) checkOutput("sv_early", 32'(sample_valid), 32'd0);
                if (c == 2) begin
                    checkOutput("sv_pulse", 32'(sample_valid), 32'd1);
                    satExp = '0;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        checkOutput($sformatf("duty%0d", ch), dutyOf(ch), 32'(expDuty[ch]));
                        satExp[ch] = expSat[ch][0];
                    end
                    checkOutput("sat", 32'(sat), 32'(satExp));
                end
                if (c == 3) checkOutput("sv_late", 32'(sample_valid), 32'd0);
            end else if (c < 4) begin
                checkOutput("sv_quiet", 32'(sample_valid), 32'd0);
            end
            if (doBrake && c == 0) begin
                brakeSequence(brakeMode);
                return;
            end
        end
        modelWindow();
    endtask

    initial begin
        reset      = 1'b1;
        brake      = 1'b0;
        coast      = 1'b0;
        enc        = '0;
        duty_base  = '0;
        gain_shift = '0;
        primed     = 1'b0;
        havePrev   = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            expDuty[ch] = 0;
            expSat[ch]  = 0;
        end

        // Reset with the encoders toggling
        for (int i = 0; i < 3; i++) begin
            enc = NUM_CH'($urandom);
            @(negedge clk);
            checkOutput("reset_duty", 32'(duty), 32'd0);
            checkOutput("reset_sat", 32'(sat), 32'd0);
            checkOutput("reset_sv", 32'(sample_valid), 32'd0);
        end
        enc   = '0;
        reset = 1'b0;
        $display("[TB] reset released, directed windows");

        for (int w = 0; w < NDIR; w++) begin
            pulses[0] = dirP0[w];
            pulses[1] = dirP1[w];
            pulses[2] = dirP2[w];
            baseNow   = dirBase[w];
            gainNow   = dirGain[w];
            applyStimulus(1'b0, 0);
        end

        // Brake mid-update (two cycles after the terminal cycle)
        for (int ch = 0; ch < NUM_CH; ch++) pulses[ch] = 3;
        baseNow = 20;
        gainNow = 0;
        applyStimulus(1'b1, 0);

        $display("[TB] randomized windows");
        for (int w = 0; w < 40; w++) begin
            for (int ch = 0; ch < NUM_CH; ch++) pulses[ch] = int'($urandom % 16);
            baseNow = int'($urandom % (DMAX + 1));
            gainNow = int'($urandom % 8);
            applyStimulus(($urandom % 6) == 0, int'($urandom % 3));
        end

        // Final quiet window so the last result gets checked
        for (int ch = 0; ch < NUM_CH; ch++) pulses[ch] = 0;
        applyStimulus(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
